// File: rtl/keyboard_seq_ctl.sv
// keyboard_seq_ctl: PS/2 scan-code sequencer feeding the game-character logic.
// Tracks the make/break/extended prefixes, keeps the held state for space,
// left and right, and arbitrates left/right so the most recently pressed
// direction wins. A space hold builds up a saturating jump charge, and the
// space release emits it as a one-cycle fire pulse.
// Optional feature: define KBD_SEQ_EXT_ARROWS_EN to make the extended left and
// right arrow codes act as aliases of the A/D keys.
module keyboard_seq_ctl #(
   parameter int unsigned CHARGE_W       = 6,
   parameter int unsigned CHARGE_MAX     = 63,
   parameter int unsigned CHARGE_DIV     = 65000,
   parameter int unsigned TIMEOUT_CYCLES = 650000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          byte_data,
   input  logic                byte_valid,
   output logic                key_space,
   output logic                key_left,
   output logic                key_right,
   output logic [CHARGE_W-1:0] jump_charge,
   output logic                jump_fire,
   output logic [CHARGE_W-1:0] jump_strength
);

   localparam int unsigned PW = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BRK     = 2'd1;
   localparam logic [1:0] ST_EXT     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   logic [1:0]          r_state;
   logic [TW-1:0]       r_tmo;
   logic                r_space_h;
   logic                r_left_h;
   logic                r_right_h;
   logic                r_last_dir;
   logic [PW-1:0]       r_presc;
   logic [CHARGE_W-1:0] r_charge;
   logic                r_fire;
   logic [CHARGE_W-1:0] r_strength;
   logic                r_key_left;
   logic                r_key_right;

   logic [1:0]          w_state_nx;
   logic                w_make;
   logic                w_brk;
   logic                w_ext;
   logic                w_is_space;
   logic                w_is_left;
   logic                w_is_right;
   logic                w_space_nx;
   logic                w_left_nx;
   logic                w_right_nx;
   logic                w_last_nx;
   logic                w_fire;
   logic                w_space_new;

   // Prefix FSM: classify each strobed byte as make/break, plain or extended.
   always_comb begin
      w_state_nx = r_state;
      w_make     = 1'b0;
      w_brk      = 1'b0;
      w_ext      = 1'b0;
      if (byte_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (byte_data == 8'hF0)      w_state_nx = ST_BRK;
               else if (byte_data == 8'hE0) w_state_nx = ST_EXT;
               else                         w_make     = 1'b1;
            end
            ST_BRK: begin
               w_brk      = 1'b1;
               w_state_nx = ST_IDLE;
            end
            ST_EXT: begin
               if (byte_data == 8'hF0) begin
                  w_state_nx = ST_EXT_BRK;
               end else begin
                  w_make     = 1'b1;
                  w_ext      = 1'b1;
                  w_state_nx = ST_IDLE;
               end
            end
            default: begin
               w_brk      = 1'b1;
               w_ext      = 1'b1;
               w_state_nx = ST_IDLE;
            end
         endcase
      end else if ((r_state != ST_IDLE) && (r_tmo == TW'(TIMEOUT_CYCLES - 1))) begin
         w_state_nx = ST_IDLE;
      end
   end

   // Key decode: plain codes always, arrow aliases only when enabled.
   always_comb begin
      w_is_space = ~w_ext & (byte_data == 8'h29);
`ifdef KBD_SEQ_EXT_ARROWS_EN
      w_is_left  = (~w_ext & (byte_data == 8'h1C)) | (w_ext & (byte_data == 8'h6B));
      w_is_right = (~w_ext & (byte_data == 8'h23)) | (w_ext & (byte_data == 8'h74));
`else
      w_is_left  = ~w_ext & (byte_data == 8'h1C);
      w_is_right = ~w_ext & (byte_data == 8'h23);
`endif
   end

   // Next held state; a typematic repeat of a held key leaves last_dir alone.
   always_comb begin
      w_space_nx  = r_space_h;
      w_left_nx   = r_left_h;
      w_right_nx  = r_right_h;
      w_last_nx   = r_last_dir;
      w_space_new = w_make & w_is_space & ~r_space_h;
      w_fire      = w_brk & w_is_space & r_space_h;
      if (w_make & w_is_space) w_space_nx = 1'b1;
      if (w_make & w_is_left) begin
         w_left_nx = 1'b1;
         if (!r_left_h) w_last_nx = DIR_LEFT;
      end
      if (w_make & w_is_right) begin
         w_right_nx = 1'b1;
         if (!r_right_h) w_last_nx = DIR_RIGHT;
      end
      if (w_brk & w_is_space) w_space_nx = 1'b0;
      if (w_brk & w_is_left)  w_left_nx  = 1'b0;
      if (w_brk & w_is_right) w_right_nx = 1'b0;
   end

   // FSM state and prefix timeout counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_tmo   <= '0;
      end else begin
         r_state <= w_state_nx;
         if (byte_valid || (r_state == ST_IDLE)) r_tmo <= '0;
         else                                    r_tmo <= r_tmo + TW'(1);
      end
   end

   // Held bits and arbitrated direction outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_space_h   <= 1'b0;
         r_left_h    <= 1'b0;
         r_right_h   <= 1'b0;
         r_last_dir  <= DIR_RIGHT;
         r_key_left  <= 1'b0;
         r_key_right <= 1'b0;
      end else begin
         r_space_h   <= w_space_nx;
         r_left_h    <= w_left_nx;
         r_right_h   <= w_right_nx;
         r_last_dir  <= w_last_nx;
         r_key_left  <= w_left_nx & (~w_right_nx | (w_last_nx == DIR_LEFT));
         r_key_right <= w_right_nx & (~w_left_nx | (w_last_nx == DIR_RIGHT));
      end
   end

   // Jump charge prescaler, saturating charge and fire/strength latch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_presc    <= '0;
         r_charge   <= '0;
         r_fire     <= 1'b0;
         r_strength <= '0;
      end else begin
         r_fire <= w_fire;
         if (w_fire) begin
            r_strength <= r_charge;
            r_charge   <= '0;
            r_presc    <= '0;
         end else if (w_space_new) begin
            r_charge <= '0;
            r_presc  <= '0;
         end else if (r_space_h) begin
            if (r_presc == PW'(CHARGE_DIV - 1)) begin
               r_presc <= '0;
               if (r_charge != CHARGE_W'(CHARGE_MAX)) r_charge <= r_charge + CHARGE_W'(1);
            end else begin
               r_presc <= r_presc + PW'(1);
            end
         end
      end
   end

   assign key_space     = r_space_h;
   assign key_left      = r_key_left;
   assign key_right     = r_key_right;
   assign jump_charge   = r_charge;
   assign jump_fire     = r_fire;
   assign jump_strength = r_strength;

endmodule

// File: tb/tb_keyboard_seq_ctl.sv
// Directed bench for keyboard_seq_ctl with a short prescaler and timeout.
module tb_keyboard_seq_ctl;

   localparam int unsigned W   = 6;
   localparam int unsigned MAX = 63;
   localparam int unsigned DIV = 4;
   localparam int unsigned TMO = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [7:0]   byte_data = '0;
   logic         byte_valid = 1'b0;
   logic         key_space, key_left, key_right, jump_fire;
   logic [W-1:0] jump_charge, jump_strength;

   int n_tests = 0;
   int n_fail  = 0;

   keyboard_seq_ctl #(
      .CHARGE_W(W), .CHARGE_MAX(MAX), .CHARGE_DIV(DIV), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
      .key_space(key_space), .key_left(key_left), .key_right(key_right),
      .jump_charge(jump_charge), .jump_fire(jump_fire), .jump_strength(jump_strength)
   );

   always #5 clk = ~clk;

   // Called at a negedge; byte is captured on the next posedge and the task
   // returns at the following negedge. Consecutive calls are back-to-back.
   task automatic strobe(input logic [7:0] b);
      byte_data  = b;
      byte_valid = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic test_reset;
      n_tests++;
      if ({key_space, key_left, key_right, jump_fire, jump_charge, jump_strength} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got sp=%b l=%b r=%b f=%b c=%0d s=%0d, want all 0",
                  key_space, key_left, key_right, jump_fire, jump_charge, jump_strength);
      end
   endtask

   task automatic test_charge_fire;
      strobe(8'h29);
      n_tests++;
      if (key_space !== 1'b1 || jump_charge !== 6'd0) begin
         n_fail++; $display("FAIL charge_make: sp=%b c=%0d, want sp=1 c=0", key_space, jump_charge);
      end
      repeat (11) @(negedge clk);
      n_tests++;
      if (jump_charge !== 6'd2) begin
         n_fail++; $display("FAIL charge_11cyc: got %0d want 2", jump_charge);
      end
      @(negedge clk);
      n_tests++;
      if (jump_charge !== 6'd3) begin
         n_fail++; $display("FAIL charge_12cyc: got %0d want 3", jump_charge);
      end
      strobe(8'hF0);
      strobe(8'h29);
      n_tests++;
      if (jump_fire !== 1'b1 || jump_strength !== 6'd3 || jump_charge !== 6'd0 || key_space !== 1'b0) begin
         n_fail++;
         $display("FAIL fire_pulse: f=%b s=%0d c=%0d sp=%b, want f=1 s=3 c=0 sp=0",
                  jump_fire, jump_strength, jump_charge, key_space);
      end
      @(negedge clk);
      n_tests++;
      if (jump_fire !== 1'b0 || jump_strength !== 6'd3) begin
         n_fail++; $display("FAIL fire_one_cycle: f=%b s=%0d, want f=0 s=3", jump_fire, jump_strength);
      end
   endtask

   task automatic test_arbitration;
      strobe(8'h1C);
      n_tests++;
      if (key_left !== 1'b1 || key_right !== 1'b0) begin
         n_fail++; $display("FAIL arb_left: l=%b r=%b want 1 0", key_left, key_right);
      end
      strobe(8'h23);
      n_tests++;
      if (key_left !== 1'b0 || key_right !== 1'b1) begin
         n_fail++; $display("FAIL arb_right_wins: l=%b r=%b want 0 1", key_left, key_right);
      end
      strobe(8'h1C);
      n_tests++;
      if (key_left !== 1'b0 || key_right !== 1'b1) begin
         n_fail++; $display("FAIL arb_typematic: l=%b r=%b want 0 1", key_left, key_right);
      end
      strobe(8'hF0);
      strobe(8'h23);
      n_tests++;
      if (key_left !== 1'b1 || key_right !== 1'b0) begin
         n_fail++; $display("FAIL arb_loser_returns: l=%b r=%b want 1 0", key_left, key_right);
      end
      strobe(8'hF0);
      strobe(8'h1C);
      n_tests++;
      if (key_left !== 1'b0 || key_right !== 1'b0) begin
         n_fail++; $display("FAIL arb_all_released: l=%b r=%b want 0 0", key_left, key_right);
      end
   endtask

   task automatic test_saturation;
      logic [W-1:0] prev;
      int           drops;
      drops = 0;
      strobe(8'h29);
      prev = jump_charge;
      for (int i = 0; i < 300; i++) begin
         if (i % 20 == 0) strobe(8'h29);
         else             @(negedge clk);
         if (jump_charge < prev) drops++;
         prev = jump_charge;
      end
      n_tests++;
      if (drops != 0) begin
         n_fail++; $display("FAIL sat_no_restart: saw %0d drops, want 0", drops);
      end
      n_tests++;
      if (jump_charge !== 6'd63) begin
         n_fail++; $display("FAIL sat_value: got %0d want 63", jump_charge);
      end
      strobe(8'hF0);
      strobe(8'h29);
      n_tests++;
      if (jump_fire !== 1'b1 || jump_strength !== 6'd63) begin
         n_fail++; $display("FAIL sat_fire: f=%b s=%0d want f=1 s=63", jump_fire, jump_strength);
      end
   endtask

   task automatic test_timeout;
      strobe(8'hF0);
      repeat (TMO) @(negedge clk);
      strobe(8'h29);
      n_tests++;
      if (key_space !== 1'b1 || jump_fire !== 1'b0) begin
         n_fail++; $display("FAIL timeout_make: sp=%b f=%b want sp=1 f=0", key_space, jump_fire);
      end
      strobe(8'hF0);
      strobe(8'h29);
      @(negedge clk);
      // Now hold space again and land the break byte exactly on the expiry cycle.
      strobe(8'h29);
      strobe(8'hF0);
      repeat (TMO - 1) @(negedge clk);
      strobe(8'h29);
      n_tests++;
      if (key_space !== 1'b0 || jump_fire !== 1'b1 || jump_strength !== 6'd4) begin
         n_fail++;
         $display("FAIL timeout_byte_wins: sp=%b f=%b s=%0d want sp=0 f=1 s=4",
                  key_space, jump_fire, jump_strength);
      end
   endtask

   task automatic test_no_fire;
      int fires;
      fires = 0;
      @(negedge clk);
      strobe(8'hF0);
      strobe(8'h29);
      if (jump_fire) fires++;
      @(negedge clk);
      if (jump_fire) fires++;
      n_tests++;
      if (fires != 0 || key_space !== 1'b0 || jump_strength !== 6'd4) begin
         n_fail++; $display("FAIL break_unheld: fires=%0d sp=%b s=%0d want 0 0 4", fires, key_space, jump_strength);
      end
   endtask

   task automatic test_reset_mid_charge;
      int fires;
      fires = 0;
      strobe(8'h29);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if ({key_space, key_left, key_right, jump_fire, jump_charge, jump_strength} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_charge: sp=%b f=%b c=%0d s=%0d want all 0",
                  key_space, jump_fire, jump_charge, jump_strength);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (jump_fire || jump_charge != 0 || key_space) fires++;
      end
      n_tests++;
      if (fires != 0) begin
         n_fail++; $display("FAIL reset_no_fire: %0d bad cycles want 0", fires);
      end
   endtask

   task automatic test_ext_arrows;
      logic exp_l;
`ifdef KBD_SEQ_EXT_ARROWS_EN
      exp_l = 1'b1;
`else
      exp_l = 1'b0;
`endif
      strobe(8'hE0);
      strobe(8'h6B);
      n_tests++;
      if (key_left !== exp_l || key_right !== 1'b0 || key_space !== 1'b0 || jump_fire !== 1'b0) begin
         n_fail++; $display("FAIL ext_left_arrow: l=%b r=%b want l=%b r=0", key_left, key_right, exp_l);
      end
      strobe(8'hE0);
      strobe(8'hF0);
      strobe(8'h6B);
      n_tests++;
      if (key_left !== 1'b0 || key_right !== 1'b0) begin
         n_fail++; $display("FAIL ext_left_break: l=%b r=%b want 0 0", key_left, key_right);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      test_reset;
      test_charge_fire;
      test_arbitration;
      test_saturation;
      test_timeout;
      test_no_fire;
      test_reset_mid_charge;
      test_ext_arrows;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
